// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - frame-synchronous screen select, fade and game gating
// Screen and brightness updates happen only on the cycle after a frame tick or a crash.
module screen_sequencer #(
  parameter int FADE_FRAMES = 2,
  parameter int OVER_FRAMES = 180
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start_req,
  input  logic       crash,
  output logic [1:0] screen_sel,
  output logic [3:0] bright,
  output logic       game_en,
  output logic       busy
);

  localparam int DW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam int HW = $clog2(OVER_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(FADE_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(OVER_FRAMES - 1);

  typedef enum logic [2:0] {
    S_START,
    S_FADE_OUT,
    S_FADE_IN,
    S_GAME,
    S_OVER
  } state_t;

  state_t        state;
  logic [1:0]    target;
  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic          vblnk_d;
  logic          start_d;
  logic          tick;
  logic          sedge;
  logic          step;

  assign tick  = vblnk & ~vblnk_d;
  // start_d resets high so a button held through reset is not seen as an edge
  assign sedge = start_req & ~start_d;
  assign step  = tick && (div == DIV_LAST);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= S_START;
      screen_sel <= 2'd0;
      bright     <= 4'd15;
      game_en    <= 1'b0;
      busy       <= 1'b0;
      target     <= 2'd0;
      div        <= '0;
      hcnt       <= '0;
      vblnk_d    <= 1'b0;
      start_d    <= 1'b1;
    end else begin
      vblnk_d <= vblnk;
      start_d <= start_req;
      case (state)
        S_START: begin
          if (sedge) begin
            state  <= S_FADE_OUT;
            target <= 2'd1;
            div    <= '0;
            busy   <= 1'b1;
          end
        end
        S_FADE_OUT: begin
          if (step) begin
            div <= '0;
            if (bright == 4'd1) begin
              bright     <= 4'd0;
              screen_sel <= target;
              state      <= S_FADE_IN;
            end else if (bright != 4'd0) begin
              bright <= bright - 4'd1;
            end
          end else if (tick) begin
            div <= div + 1'b1;
          end
        end
        S_FADE_IN: begin
          if (step) begin
            div <= '0;
            if (bright == 4'd14) begin
              bright <= 4'd15;
              busy   <= 1'b0;
              if (target == 2'd1) begin
                state   <= S_GAME;
                game_en <= 1'b1;
              end else begin
                state <= S_START;
              end
            end else if (bright != 4'd15) begin
              bright <= bright + 4'd1;
            end
          end else if (tick) begin
            div <= div + 1'b1;
          end
        end
        S_GAME: begin
          // crash wins over a coincident tick; that tick is not counted
          if (crash) begin
            state      <= S_OVER;
            screen_sel <= 2'd2;
            bright     <= 4'd15;
            game_en    <= 1'b0;
            hcnt       <= '0;
            div        <= '0;
          end
        end
        S_OVER: begin
          if (tick) begin
            if (hcnt == HOLD_LAST) begin
              state  <= S_FADE_OUT;
              target <= 2'd0;
              div    <= '0;
              busy   <= 1'b1;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - directed self-checking bench for screen_sequencer
module tb_screen_sequencer;

  logic       pclk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b0;
  logic       vblnk = 1'b0;
  logic       start_req = 1'b0;
  logic       crash = 1'b0;
  logic [1:0] screen_sel;
  logic [3:0] bright;
  logic       game_en;
  logic       busy;

  int checks = 0;
  int errors = 0;

  screen_sequencer #(.FADE_FRAMES(2), .OVER_FRAMES(4)) dut (
    .pclk(pclk),
    .rst(rst),
    .vblnk(vblnk),
    .start_req(start_req),
    .crash(crash),
    .screen_sel(screen_sel),
    .bright(bright),
    .game_en(game_en),
    .busy(busy)
  );

  always #5 if (clk_run) pclk = ~pclk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic ticks(input int n, input int exp_busy);
    for (int i = 0; i < n; i++) begin
      vblnk = 1'b1;
      cyc();
      vblnk = 1'b0;
      cyc();
      check("busy_during_ticks", int'(busy), exp_busy);
    end
  endtask

  task automatic check_out(input string tag, input int sel, input int br, input int ge, input int bz);
    check({tag, "_sel"}, int'(screen_sel), sel);
    check({tag, "_bright"}, int'(bright), br);
    check({tag, "_game_en"}, int'(game_en), ge);
    check({tag, "_busy"}, int'(busy), bz);
  endtask

  task automatic start_pulse();
    start_req = 1'b1;
    cyc();
    start_req = 1'b0;
    check_out("start_next", 0, 15, 0, 1);
    cyc();
  endtask

  initial begin
    // asynchronous reset with the clock stopped
    #3 rst = 1'b1;
    #1 check_out("reset_noclk", 0, 15, 0, 0);
    start_req = 1'b1;
    clk_run = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    check_out("held_start", 0, 15, 0, 0);
    start_req = 1'b0;
    cyc();

    crash = 1'b1; cyc(); crash = 1'b0; cyc();
    check_out("crash_in_start", 0, 15, 0, 0);

    // start flow with a crash during the fade
    start_pulse();
    ticks(2, 1);  check("flow_t2", int'(bright), 14);
    ticks(8, 1);
    crash = 1'b1; cyc(); crash = 1'b0; cyc();
    check_out("crash_in_fade", 0, 10, 0, 1);
    ticks(20, 1); check_out("flow_t30", 1, 0, 0, 1);
    ticks(29, 1); check("flow_t59", int'(bright), 14);
    ticks(1, 0);  check_out("flow_t60", 1, 15, 1, 0);

    start_req = 1'b1; cyc(); start_req = 1'b0; cyc();
    ticks(2, 0);
    check_out("game_ignore", 1, 15, 1, 0);

    // plain crash then hold of 4 ticks
    crash = 1'b1; cyc(); crash = 1'b0;
    check_out("crash_next", 2, 15, 0, 0);
    start_req = 1'b1; cyc(); start_req = 1'b0; cyc();
    check_out("over_ignore", 2, 15, 0, 0);
    ticks(3, 0);
    ticks(1, 1);  check_out("over_t4", 2, 15, 0, 1);
    ticks(30, 1); check_out("over_fade30", 0, 0, 0, 1);
    ticks(29, 1);
    ticks(1, 0);  check_out("over_fade60", 0, 15, 0, 0);

    // sedge coincident with tick: that tick is not counted
    start_req = 1'b1; vblnk = 1'b1; cyc();
    start_req = 1'b0; vblnk = 1'b0; cyc();
    check_out("sedge_tick", 0, 15, 0, 1);
    ticks(1, 1);  check("sedge_tick_t1", int'(bright), 15);
    ticks(1, 1);  check("sedge_tick_t2", int'(bright), 14);
    ticks(57, 1);
    ticks(1, 0);  check_out("sedge_tick_t60", 1, 15, 1, 0);

    // crash coincident with tick: hold is still exactly 4 ticks
    crash = 1'b1; vblnk = 1'b1; cyc();
    crash = 1'b0; vblnk = 1'b0; cyc();
    check_out("crash_tick", 2, 15, 0, 0);
    ticks(3, 0);
    ticks(1, 1);
    ticks(59, 1);
    ticks(1, 0);  check_out("crash_tick_end", 0, 15, 0, 0);

    // reset mid FADE_IN
    start_pulse();
    ticks(44, 1); check_out("mid_fadein", 1, 7, 0, 1);
    #2 rst = 1'b1;
    #1 check_out("reset_mid", 0, 15, 0, 0);
    cyc();
    rst = 1'b0;
    cyc();
    check_out("after_reset", 0, 15, 0, 0);
    start_pulse();
    ticks(2, 1);  check("rerun_t2", int'(bright), 14);
    ticks(28, 1); check_out("rerun_t30", 1, 0, 0, 1);
    ticks(29, 1);
    ticks(1, 0);  check_out("rerun_t60", 1, 15, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
